// File: rtl/ppc_mem_resp.sv
// ppc_mem_resp: single-ported doubleword store shared by a write port and two read ports with fixed-latency read responses.
// Optional byte write enables (wr_be) when PPC_MEM_RESP_BYTE_WRITE_EN is defined.
module ppc_mem_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd0_req,
    input  logic [0:60] rd0_addr,
    output logic        rd0_ready,
    output logic        rd0_valid,
    output logic [0:63] rd0_data,
    output logic        rd0_err,
    input  logic        rd1_req,
    input  logic [0:60] rd1_addr,
    output logic        rd1_ready,
    output logic        rd1_valid,
    output logic [0:63] rd1_data,
    output logic        rd1_err,
    input  logic        wr_req,
    input  logic [0:60] wr_addr,
    input  logic [0:63] wr_data,
`ifdef PPC_MEM_RESP_BYTE_WRITE_EN
    input  logic [0:7]  wr_be,
`endif
    output logic        wr_ready
);
    logic [0:63]           mem [2**DEPTH_LOG2];
    logic [0:63]           data_q [LAT];
    logic [LAT-1:0]        vld_q, port_q, err_q;
    logic                  ptr_q, ptr_d;
    logic                  rd_acc, rd_sel, rd_oor, wr_ok;
    logic [0:60]           rd_addr;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

    // Write always wins; reads alternate, ptr_q=1 favours rd1 on a tie.
    assign wr_ready  = !reset && wr_req;
    assign rd0_ready = !reset && !wr_req && rd0_req && (!rd1_req || !ptr_q);
    assign rd1_ready = !reset && !wr_req && rd1_req && (!rd0_req || ptr_q);

    assign rd_acc  = rd0_ready || rd1_ready;
    assign rd_sel  = rd1_ready;
    assign rd_addr = rd_sel ? rd1_addr : rd0_addr;
    assign rd_idx  = rd_addr[61-DEPTH_LOG2:60];
    assign wr_idx  = wr_addr[61-DEPTH_LOG2:60];
    assign rd_oor  = rd_addr[0:60-DEPTH_LOG2] != '0;
    assign wr_ok   = wr_addr[0:60-DEPTH_LOG2] == '0;
    assign ptr_d   = rd0_ready ? 1'b1 : rd1_ready ? 1'b0 : ptr_q;

    always_ff @(posedge clk) begin
        if (wr_ready && wr_ok) begin
`ifdef PPC_MEM_RESP_BYTE_WRITE_EN
            for (int b = 0; b < 8; b++)
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
`else
            mem[wr_idx] <= wr_data;
`endif
        end
        if (rd_acc) data_q[0] <= mem[rd_idx];
        for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            port_q <= '0;
            err_q  <= '0;
            ptr_q  <= 1'b0;
        end else begin
            vld_q[0]  <= rd_acc;
            port_q[0] <= rd_sel;
            err_q[0]  <= rd_oor;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
                err_q[i]  <= err_q[i-1];
            end
            ptr_q <= ptr_d;
        end
    end

    // Data pipeline is unreset, so outputs are gated by the reset-cleared valid bits.
    assign rd0_valid = vld_q[LAT-1] && !port_q[LAT-1];
    assign rd1_valid = vld_q[LAT-1] && port_q[LAT-1];
    assign rd0_err   = rd0_valid && err_q[LAT-1];
    assign rd1_err   = rd1_valid && err_q[LAT-1];
    assign rd0_data  = (rd0_valid && !err_q[LAT-1]) ? data_q[LAT-1] : '0;
    assign rd1_data  = (rd1_valid && !err_q[LAT-1]) ? data_q[LAT-1] : '0;
endmodule
